// File: rtl/apb_master_ctrl.sv
// Command-driven APB4 requester: accepts read/write commands over valid/ready and runs SETUP/ACCESS.
// Optional ACCESS-phase timeout abort is built when APB_TIMEOUT_EN is defined.
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    output logic                pwrite,
    output logic                psel,
    output logic                penable,
    input  logic                pready,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pslverr
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state_reg;
    logic   accept;
    logic   abort;

    assign cmd_ready = (state_reg == ST_IDLE) || ((state_reg == ST_ACCESS) && pready);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_reg != ST_IDLE);

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tcnt_reg;

    // The counter holds the number of wait cycles already seen, so the
    // TIMEOUT-th consecutive wait cycle is the one that aborts.
    assign abort = (state_reg == ST_ACCESS) && !pready &&
                   (tcnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_reg <= '0;
        end else if (state_reg == ST_ACCESS && !pready && !abort) begin
            tcnt_reg <= tcnt_reg + 1'b1;
        end else begin
            tcnt_reg <= '0;
        end
    end
`else
    assign abort = 1'b0;
`endif

    // Transfer attributes only move on an accepted command and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr  <= '0;
            pwdata <= '0;
            pstrb  <= '0;
            pwrite <= 1'b0;
        end else if (accept) begin
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            pstrb  <= cmd_write ? cmd_strb : {STRB_W{1'b0}};
            pwrite <= cmd_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    penable <= 1'b0;
                    if (accept) begin
                        psel      <= 1'b1;
                        state_reg <= ST_SETUP;
                    end else begin
                        psel <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    penable   <= 1'b1;
                    state_reg <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        rsp_rdata <= pwrite ? {DATA_W{1'b0}} : prdata;
                        penable   <= 1'b0;
                        if (accept) begin
                            psel      <= 1'b1;
                            state_reg <= ST_SETUP;
                        end else begin
                            psel      <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end else if (abort) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
